// File: rtl/riscv_exec_writeback.sv
// riscv_exec_writeback
//   Execute/writeback stage for decoded R-type operations. Accepts one
//   operation through a valid/ready handshake and presents the result on
//   the register-file write port. Shifts run one bit per cycle in a SHIFT
//   state; every other operation (and shift by 0) goes straight to WB.
//
//   Optional feature macro: RISCV_EXEC_FAST_SHIFT_EN
//     defined   -> shifts use a barrel shifter, SHIFT is never entered and
//                  every operation reaches WB one cycle after acceptance.
//     undefined -> iterative shifter.
//
// Ports
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-low reset
//   in_valid  in   decoded operation present
//   in_ready  out  operation can be accepted this cycle (state == IDLE)
//   in_fn3    in   operation select
//   in_fn7    in   operation modifier, only bit 5 is used
//   in_rd     in   destination register
//   in_op1    in   rs1 data
//   in_op2    in   rs2 data
//   wb_en     out  one-cycle write strobe (never for x0)
//   wb_rd     out  write address, holds outside WB
//   wb_data   out  write data, holds outside WB
//   busy      out  operation in flight
module riscv_exec_writeback #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_fn3,
    input  logic [6:0]         in_fn7,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic [XLEN-1:0]    in_op1,
    input  logic [XLEN-1:0]    in_op2,
    output logic               wb_en,
    output logic [RADDR_W-1:0] wb_rd,
    output logic [XLEN-1:0]    wb_data,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WB    = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [RADDR_W-1:0] r_wb_rd;
    logic [XLEN-1:0]    r_wb_data;
    logic               w_go_shift;
    logic               w_unused_fn7;

    assign w_unused_fn7 = ^{in_fn7[6], in_fn7[4:0]};

    // Single-cycle result. Shift opcodes only reach this path in the
    // iterative build when the shift amount is 0, so they pass op1 through.
    function automatic logic [XLEN-1:0] f_alu(input logic [2:0]      fn3,
                                              input logic            alt,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        logic [XLEN-1:0] res;
`ifdef RISCV_EXEC_FAST_SHIFT_EN
        logic [SHAMT_W-1:0] sh;
        sh = b[SHAMT_W-1:0];
`endif
        res = '0;
        case (fn3)
            3'b000: res = alt ? (a - b) : (a + b);
`ifdef RISCV_EXEC_FAST_SHIFT_EN
            3'b001: res = a << sh;
            3'b101: res = alt ? $unsigned($signed(a) >>> sh) : (a >> sh);
`else
            3'b001: res = a;
            3'b101: res = a;
`endif
            3'b010: res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            3'b011: res = {{(XLEN-1){1'b0}}, (a < b)};
            3'b100: res = a ^ b;
            3'b110: res = a | b;
            default: res = a & b;
        endcase
        return res;
    endfunction

`ifndef RISCV_EXEC_FAST_SHIFT_EN
    logic [XLEN-1:0]    r_work;
    logic [SHAMT_W-1:0] r_cnt;
    logic [RADDR_W-1:0] r_rd;
    logic               r_left;
    logic               r_arith;
    logic [XLEN-1:0]    w_step;
    logic [SHAMT_W-1:0] w_shamt;

    function automatic logic [XLEN-1:0] f_shift_step(input logic            left,
                                                     input logic            arith,
                                                     input logic [XLEN-1:0] x);
        if (left)
            return {x[XLEN-2:0], 1'b0};
        else
            return {arith & x[XLEN-1], x[XLEN-1:1]};
    endfunction

    assign w_shamt    = in_op2[SHAMT_W-1:0];
    assign w_go_shift = (in_fn3[1:0] == 2'b01) && (w_shamt != '0);
    assign w_step     = f_shift_step(r_left, r_arith, r_work);
`else
    assign w_go_shift = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (in_valid) w_state_nxt = w_go_shift ? SHIFT : WB;
`ifndef RISCV_EXEC_FAST_SHIFT_EN
            SHIFT: if (r_cnt == SHAMT_W'(1)) w_state_nxt = WB;
`endif
            WB:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_wb_rd   <= '0;
            r_wb_data <= '0;
`ifndef RISCV_EXEC_FAST_SHIFT_EN
            r_work    <= '0;
            r_cnt     <= '0;
            r_rd      <= '0;
            r_left    <= 1'b0;
            r_arith   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
`ifndef RISCV_EXEC_FAST_SHIFT_EN
                        if (w_go_shift) begin
                            r_work  <= in_op1;
                            r_cnt   <= w_shamt;
                            r_rd    <= in_rd;
                            r_left  <= ~in_fn3[2];
                            r_arith <= in_fn7[5];
                        end else
`endif
                        begin
                            // Write port only changes when entering WB so it
                            // holds its last value everywhere else.
                            r_wb_rd   <= in_rd;
                            r_wb_data <= f_alu(in_fn3, in_fn7[5], in_op1, in_op2);
                        end
                    end
                end
`ifndef RISCV_EXEC_FAST_SHIFT_EN
                SHIFT: begin
                    r_work <= w_step;
                    r_cnt  <= r_cnt - SHAMT_W'(1);
                    if (r_cnt == SHAMT_W'(1)) begin
                        r_wb_rd   <= r_rd;
                        r_wb_data <= w_step;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign in_ready = (r_state == IDLE);
    assign busy     = (r_state != IDLE);
    assign wb_en    = (r_state == WB) && (r_wb_rd != '0);
    assign wb_rd    = r_wb_rd;
    assign wb_data  = r_wb_data;

endmodule

// File: tb/tb_riscv_exec_writeback.sv
module tb_riscv_exec_writeback;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fn3;
    logic [6:0]  in_fn7;
    logic [4:0]  in_rd;
    logic [31:0] in_op1;
    logic [31:0] in_op2;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        busy;

    int n_vec;
    int n_err;

    riscv_exec_writeback #(.XLEN(32), .RADDR_W(5), .SHAMT_W(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_fn3(in_fn3), .in_fn7(in_fn7), .in_rd(in_rd), .in_op1(in_op1),
        .in_op2(in_op2), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles from acceptance to the WB cycle for a shift by n.
    function automatic int shift_lat(input int n);
`ifdef RISCV_EXEC_FAST_SHIFT_EN
        return 1;
`else
        return (n == 0) ? 1 : n + 1;
`endif
    endfunction

    // Present one operation on an idle block; returns at the negedge of the
    // first cycle after the accepting edge.
    task automatic apply_op(input logic [2:0] f3, input logic [6:0] f7,
                            input logic [4:0] rd, input logic [31:0] a,
                            input logic [31:0] b);
        @(negedge clk);
        in_fn3 = f3; in_fn7 = f7; in_rd = rd; in_op1 = a; in_op2 = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_op(input string nm, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input logic exp_en);
        apply_op(f3, f7, rd, a, b);
        for (int c = 1; c < lat; c++) begin
            n_vec++;
            if (wb_en !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL %s_inflight c=%0d got en=%b rdy=%b busy=%b exp en=0 rdy=0 busy=1",
                         nm, c, wb_en, in_ready, busy);
            end
            @(negedge clk);
        end
        n_vec++;
        if (wb_en !== exp_en) begin
            n_err++; $display("FAIL %s_en got %b exp %b", nm, wb_en, exp_en);
        end
        n_vec++;
        if (wb_rd !== rd) begin
            n_err++; $display("FAIL %s_rd got %0d exp %0d", nm, wb_rd, rd);
        end
        n_vec++;
        if (wb_data !== exp) begin
            n_err++; $display("FAIL %s_data got %h exp %h", nm, wb_data, exp);
        end
        n_vec++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL %s_wbstate got rdy=%b busy=%b exp rdy=0 busy=1", nm, in_ready, busy);
        end
        @(negedge clk);
        n_vec++;
        if (wb_en !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || wb_data !== exp) begin
            n_err++;
            $display("FAIL %s_after got en=%b rdy=%b busy=%b data=%h exp en=0 rdy=1 busy=0 data=%h",
                     nm, wb_en, in_ready, busy, wb_data, exp);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1 || wb_en !== 1'b0 || busy !== 1'b0 || wb_data !== 32'h0 || wb_rd !== 5'd0) begin
            n_err++;
            $display("FAIL reset_held got rdy=%b en=%b busy=%b rd=%0d data=%h exp 1 0 0 0 0",
                     in_ready, wb_en, busy, wb_rd, wb_data);
        end
        reset = 1'b1;
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1 || wb_en !== 1'b0 || busy !== 1'b0 || wb_data !== 32'h0) begin
            n_err++;
            $display("FAIL reset_release got rdy=%b en=%b busy=%b data=%h exp 1 0 0 0",
                     in_ready, wb_en, busy, wb_data);
        end
    endtask

    task automatic test_add_sub;
        run_op("add",  3'b000, 7'h00, 5'd3,  32'd2,        32'd3, 32'd5,        1, 1'b1);
        run_op("sub",  3'b000, 7'h20, 5'd3,  32'd2,        32'd3, 32'hFFFFFFFF, 1, 1'b1);
        run_op("wrap", 3'b000, 7'h00, 5'd6,  32'hFFFFFFFF, 32'd1, 32'h0,        1, 1'b1);
        // fn7 = 0x5F has bit 5 clear: still an add
        run_op("fn7ign", 3'b000, 7'h5F, 5'd8, 32'd2,       32'd3, 32'd5,        1, 1'b1);
    endtask

    task automatic test_logic;
        run_op("xor", 3'b100, 7'h00, 5'd10, 32'h0000F0F0, 32'h00000FF0, 32'h0000FF00, 1, 1'b1);
        run_op("or",  3'b110, 7'h00, 5'd11, 32'h0000F000, 32'h0000000F, 32'h0000F00F, 1, 1'b1);
        run_op("and", 3'b111, 7'h00, 5'd12, 32'h000000F0, 32'h0000003C, 32'h00000030, 1, 1'b1);
    endtask

    task automatic test_compare;
        run_op("slt_x0", 3'b010, 7'h00, 5'd0, 32'hFFFFFFFF, 32'd1, 32'd1, 1, 1'b0);
        run_op("sltu",   3'b011, 7'h00, 5'd5, 32'hFFFFFFFF, 32'd1, 32'd0, 1, 1'b1);
    endtask

    task automatic test_shift;
        run_op("sra4",  3'b101, 7'h20, 5'd4,  32'h80000000, 32'd4,    32'hF8000000, shift_lat(4),  1'b1);
        run_op("srl4",  3'b101, 7'h00, 5'd4,  32'h80000000, 32'd4,    32'h08000000, shift_lat(4),  1'b1);
        run_op("sra1",  3'b101, 7'h20, 5'd13, 32'h7FFFFFFF, 32'd1,    32'h3FFFFFFF, shift_lat(1),  1'b1);
        run_op("sll31", 3'b001, 7'h00, 5'd14, 32'h00000001, 32'd31,   32'h80000000, shift_lat(31), 1'b1);
        run_op("sllhi", 3'b001, 7'h00, 5'd15, 32'h00000001, 32'h24,   32'h00000010, shift_lat(4),  1'b1);
        run_op("sll0",  3'b001, 7'h00, 5'd16, 32'h00001234, 32'h20,   32'h00001234, shift_lat(0),  1'b1);
    endtask

    task automatic test_reset_abort;
        int pulses;
        apply_op(3'b001, 7'h00, 5'd9, 32'h00000001, 32'd31);
`ifndef RISCV_EXEC_FAST_SHIFT_EN
        for (int c = 0; c < 10; c++) begin
            n_vec++;
            if (wb_en !== 1'b0 || busy !== 1'b1) begin
                n_err++; $display("FAIL abort_shifting c=%0d got en=%b busy=%b exp 0 1", c, wb_en, busy);
            end
            @(negedge clk);
        end
`else
        @(negedge clk);
`endif
        reset = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || wb_en !== 1'b0 || wb_data !== 32'h0 || wb_rd !== 5'd0) begin
            n_err++;
            $display("FAIL abort_async got rdy=%b busy=%b en=%b rd=%0d data=%h exp 1 0 0 0 0",
                     in_ready, busy, wb_en, wb_rd, wb_data);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (wb_en !== 1'b0 || busy !== 1'b0) pulses++;
        end
        n_vec++;
        if (pulses != 0) begin
            n_err++; $display("FAIL abort_nowrite got %0d active cycles exp 0", pulses);
        end
        run_op("and_after", 3'b111, 7'h00, 5'd7, 32'h000000F0, 32'h0000003C, 32'h00000030, 1, 1'b1);
    endtask

    task automatic test_back_to_back;
        logic [2:0]  f3 [3];
        logic [6:0]  f7 [3];
        logic [4:0]  rd [3];
        logic [31:0] a  [3];
        logic [31:0] b  [3];
        logic [31:0] ex [3];
        int idx;
        int pulses;
        int cyc;
        logic rdy;
        f3[0] = 3'b000; f7[0] = 7'h00; rd[0] = 5'd1; a[0] = 32'd10;        b[0] = 32'd20; ex[0] = 32'd30;
        f3[1] = 3'b101; f7[1] = 7'h20; rd[1] = 5'd2; a[1] = 32'hFFFFFF00; b[1] = 32'd2;  ex[1] = 32'hFFFFFFC0;
        f3[2] = 3'b100; f7[2] = 7'h00; rd[2] = 5'd3; a[2] = 32'h000000FF; b[2] = 32'h0F; ex[2] = 32'h000000F0;
        idx = 0; pulses = 0; cyc = 0;
        @(negedge clk);
        in_fn3 = f3[0]; in_fn7 = f7[0]; in_rd = rd[0]; in_op1 = a[0]; in_op2 = b[0];
        in_valid = 1'b1;
        while (cyc < 200 && (idx < 3 || busy === 1'b1)) begin
            rdy = in_ready;
            @(negedge clk);
            cyc++;
            if (wb_en === 1'b1) begin
                n_vec++;
                if (pulses >= 3) begin
                    n_err++; $display("FAIL b2b_extra_pulse got %0d exp 3", pulses + 1);
                end else if (wb_data !== ex[pulses] || wb_rd !== rd[pulses]) begin
                    n_err++;
                    $display("FAIL b2b_result%0d got rd=%0d data=%h exp rd=%0d data=%h",
                             pulses, wb_rd, wb_data, rd[pulses], ex[pulses]);
                end
                pulses++;
            end
            if (rdy === 1'b1 && idx < 3) begin
                n_vec++;
                if (in_ready !== 1'b0) begin
                    n_err++; $display("FAIL b2b_accept%0d got rdy=%b exp 0", idx, in_ready);
                end
                idx++;
                if (idx < 3) begin
                    in_fn3 = f3[idx]; in_fn7 = f7[idx]; in_rd = rd[idx]; in_op1 = a[idx]; in_op2 = b[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        n_vec++;
        if (pulses != 3 || idx != 3) begin
            n_err++; $display("FAIL b2b_count got pulses=%0d accepts=%0d exp 3 3", pulses, idx);
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        reset = 1'b0; in_valid = 1'b0;
        in_fn3 = '0; in_fn7 = '0; in_rd = '0; in_op1 = '0; in_op2 = '0;
        test_reset();
        test_add_sub();
        test_logic();
        test_compare();
        test_shift();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/riscv_exec_writeback.md
Name: riscv_exec_writeback

Overview:
- Execute/writeback end of the register-file interface: accepts one decoded R-type operation (fn3, fn7, rd, rs1/rs2 operand data) and returns the result on the register-file write port (write enable, address, data).
- Sits after fetch/decode/register-read and drives the register file's write side. Shifts are iterative (multi-cycle) and all other operations take one cycle, so the block has a valid/ready input handshake.

Parameters:
- XLEN, 32, operand/result width in bits.
- RADDR_W, 5, register address width.
- SHAMT_W, 5, shift-amount width; always log2(XLEN).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- in_valid  input  1  decoded operation present.
- in_ready  output  1  block can accept an operation this cycle.
- in_fn3  input  3  operation select.
- in_fn7  input  7  operation modifier; only bit 5 is used.
- in_rd  input  RADDR_W  destination register.
- in_op1  input  XLEN  rs1 data.
- in_op2  input  XLEN  rs2 data.
- wb_en  output  1  one-cycle register-file write strobe.
- wb_rd  output  RADDR_W  write address.
- wb_data  output  XLEN  write data.
- busy  output  1  operation in flight (state != IDLE).

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, in_ready=1, wb_en=0, wb_rd=0, wb_data=0, busy=0, and internal operand/count registers cleared. Reset mid-shift aborts the operation and produces no write. The release edge is synchronous to clk.
- States:
  - IDLE: in_ready=1. When in_valid=1, latch fn3, fn7[5], rd, op1 and op2; then go to SHIFT if fn3 is 001 or 101 and op2[4:0]!=0, otherwise go to WB.
  - SHIFT: in_ready=0. Shift the working register one bit per cycle and decrement the count. When the count reaches 1, go to WB.
  - WB: in_ready=0. Drive wb_en=1 for exactly this cycle with wb_rd and wb_data, then return to IDLE.
- Operations:
  - fn3=000: add, or sub when fn7[5]=1.
  - fn3=001: sll.
  - fn3=010: slt (signed).
  - fn3=011: sltu.
  - fn3=100: xor.
  - fn3=101: srl, or sra when fn7[5]=1.
  - fn3=110: or.
  - fn3=111: and.
- Arithmetic and width rules:
  - Results are XLEN bits; add/sub wrap modulo 2^XLEN and no carry or overflow is reported.
  - slt/sltu produce 0 or 1, zero-extended.
  - Shift amount is op2[SHAMT_W-1:0]; higher op2 bits are ignored.
  - sra replicates the sign bit on every step.
  - fn7 bits other than bit 5 are ignored.
- Latency:
  - Non-shift operations and shifts by 0: accepted at edge T, wb_en high during cycle T+1. Throughput is one operation per 2 cycles.
  - Shift by N (N>=1): wb_en high during cycle T+N+1.
- rd=0: the operation executes and occupies the WB cycle, but wb_en stays 0 (x0 is never written). wb_rd and wb_data still show the computed values.
- wb_rd and wb_data hold their last values outside WB. wb_en is 0 in every state except WB.
- in_valid while in_ready=0 is ignored; the source must hold the operation until it sees in_ready=1.
- in_ready is combinational from state only, with no dependency on in_valid.

Optional Feature:
- Macro: RISCV_EXEC_FAST_SHIFT_EN.
- Defined: shifts use a single-cycle barrel shifter, the SHIFT state is never entered, and every operation has 1-cycle latency to WB.
- Undefined: iterative SHIFT state as specified above.
- Results are identical in both builds; only latency differs.

Test Plan:
- Reset low for 3 cycles, then release -> in_ready=1, wb_en=0, wb_data=0, busy=0.
- add fn3=000, fn7=0, rd=3, op1=2, op2=3 -> next cycle wb_en=1, wb_rd=3, wb_data=5. Repeat with fn7=0x20 (sub) -> wb_data=0xFFFFFFFF.
- sra fn3=101, fn7=0x20, rd=4, op1=0x80000000, op2=4 -> wb_en=1 four cycles after the first busy cycle (5 cycles after accept), wb_data=0xF8000000; in_ready=0 throughout. With RISCV_EXEC_FAST_SHIFT_EN defined -> same data, 1 cycle after accept.
- slt fn3=010, rd=0, op1=0xFFFFFFFF, op2=1 -> WB cycle occurs with wb_data=1 and wb_en stays 0. sltu with the same operands and rd=5 -> wb_en=1, wb_data=0.
- sll by 31, then assert reset after 10 shift cycles -> wb_en never pulses, state returns to IDLE, outputs return to 0. A following and (op1=0xF0, op2=0x3C, rd=7) -> wb_data=0x30.
- in_valid held high with back-to-back operations -> accepts only on in_ready=1 cycles; each operation produces exactly one wb_en pulse.
